// File: rtl/uart_pkg.sv
// Shared constants for the parameterised UART transmitter: parity modes,
// FSM state encoding and the parity-bit helper.
package uart_pkg;

    localparam int PAR_NONE = 32'sd0;
    localparam int PAR_ODD  = 32'sd1;
    localparam int PAR_EVEN = 32'sd2;

    // Each state names the bit currently driven on txd.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit word FIFO: power-of-two depth, wrapping pointers, explicit occupancy.
// A push is refused while full, even if a pop happens on the same clock.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == LVL_FULL);
    assign empty     = (r_level == {(AW + 1){1'b0}});
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {(AW + 1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-fed, baud_tick paced, back-to-back
// frames with no idle bit when more words are queued.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          baud_tick,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0] CNT_ONE   = 4'd1;
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_rdy;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_stop;
    logic [DATA_BITS-1:0] w_rdata;

    assign in_ready    = r_rdy & ~w_full;
    assign w_push      = in_valid & in_ready;
    assign w_last_stop = (r_state == ST_STOP) && (r_stop_cnt == LAST_STOP);
    assign w_pop       = baud_tick & ~w_empty & ((r_state == ST_IDLE) | w_last_stop);

    assign txd        = r_txd;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // Frame sequencer; every state, counter and txd change waits for baud_tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_shift      <= {DATA_BITS{1'b0}};
            r_bit_cnt    <= 4'd0;
            r_stop_cnt   <= 1'b0;
            r_par        <= 1'b0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (baud_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_shift <= w_rdata;
                            r_par   <= parity_bit(^w_rdata, PARITY);
                            r_txd   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_START;
                        end else begin
                            r_txd <= 1'b1;
                        end
                    end
                    ST_START: begin
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= 4'd0;
                        r_state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (r_bit_cnt != LAST_BIT) begin
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        end else if (PARITY != PAR_NONE) begin
                            r_txd   <= r_par;
                            r_state <= ST_PARITY;
                        end else begin
                            r_txd      <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        r_txd      <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (r_stop_cnt != LAST_STOP) begin
                            r_txd      <= 1'b1;
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end else begin
                            // End of frame: chain straight into the next start bit if a word waits.
                            r_frame_done <= 1'b1;
                            if (!w_empty) begin
                                r_shift <= w_rdata;
                                r_par   <= parity_bit(^w_rdata, PARITY);
                                r_txd   <= 1'b0;
                                r_state <= ST_START;
                            end else begin
                                r_txd   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 odd, 2 even.
REQ-003 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1, 2.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set transmit FIFO entries; power of 2, at least 2.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all logic rising-edge.
REQ-006 Port rstn, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-007 Port baud_tick, input, 1 bit, SHALL be a one-clk strobe, one per bit period.
REQ-008 Port in_valid, input, 1 bit, SHALL indicate that in_data holds a word to queue.
REQ-009 Port in_data, input, DATA_BITS wide, SHALL carry the word to send, LSB transmitted first.
REQ-010 Port in_ready, output, 1 bit, SHALL be high when the FIFO is not full.
REQ-011 Port txd, output, 1 bit, SHALL be the serial line, registered, idle high.
REQ-012 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-013 Port frame_done, output, 1 bit, SHALL pulse for one clk at the end of each frame's last stop bit.
REQ-014 Port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits wide, SHALL give the current FIFO occupancy.

Function
REQ-015 A word SHALL be pushed on any clk where in_valid and in_ready are both high.
REQ-016 in_ready SHALL depend only on FIFO state, never combinationally on in_valid.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and each state names the bit currently on txd.
REQ-018 txd, the FSM state, and the bit and stop counters SHALL change only on clks where baud_tick is high.
REQ-019 IDLE: on a tick with the FIFO non-empty, the FSM SHALL pop one word into the shift register, set txd to 0, and go to START; with the FIFO empty it SHALL hold txd at 1.
REQ-020 START: on a tick, txd SHALL become bit 0, the bit counter SHALL be set to 0, and the FSM SHALL go to DATA.
REQ-021 DATA: on a tick with the counter below DATA_BITS-1, txd SHALL become the next bit and the counter SHALL increment.
REQ-022 DATA: on a tick with the counter at DATA_BITS-1, the FSM SHALL go to PARITY (txd set to the parity bit) if PARITY is not 0, otherwise to STOP (txd set to 1).
REQ-023 The parity bit SHALL be the XOR of all data bits for even parity and its inverse for odd parity.
REQ-024 PARITY: on a tick, txd SHALL become 1, the FSM SHALL go to STOP, and the stop counter SHALL be set to 0.
REQ-025 STOP: on a tick with the stop counter below STOP_BITS-1, txd SHALL stay 1 and the counter SHALL increment.
REQ-026 STOP, final stop bit: on a tick, frame_done SHALL pulse; if the FIFO is non-empty the FSM SHALL pop, set txd to 0, and go to START with no idle bit between frames, otherwise it SHALL go to IDLE.
REQ-027 A push and a pop on the same clk SHALL leave fifo_level unchanged and SHALL pop the older word.
REQ-028 A push SHALL NOT be accepted while the FIFO is full, even on a clk where a pop occurs.
REQ-029 A push into an empty FIFO on the same clk as an IDLE tick SHALL NOT be popped until the next tick.
REQ-030 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While rstn is low, the block SHALL hold txd=1, busy=0, frame_done=0, fifo_level=0, in_ready=0, state IDLE, and all counters and pointers at 0.
REQ-032 Reset asserted mid-frame SHALL immediately abort the frame, drive txd high, and discard all FIFO contents.
REQ-033 in_ready SHALL go high on the first clk after rstn deasserts.

Structure
REQ-034 Package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state encoding.
REQ-035 The FIFO SHALL be a separate sub-module, uart_tx_fifo (parameters WIDTH and DEPTH), exposing push, pop, full, empty, and level.

Verification
REQ-036 Scenario 1: DATA_BITS=8, PARITY=2, STOP_BITS=1, push 0xA5 -> txd per tick is 0,1,0,1,0,0,1,0,1, parity 0, stop 1, with frame_done pulsing once.
REQ-037 Scenario 2: the same frame with PARITY=1 -> parity bit is 1; with PARITY=0 -> the stop bit follows the 8th data bit directly.
REQ-038 Scenario 3: DATA_BITS=7, STOP_BITS=2, push 0x41 -> 0,1,0,0,0,0,0,1,1,1, then IDLE.
REQ-039 Scenario 4: FIFO_DEPTH=4, push 5 words back-to-back -> in_ready drops after 4 words are accepted; frames are transmitted contiguously with no idle bit between them; all words arrive in order.
REQ-040 Scenario 5: assert rstn low at DATA bit 3 with 2 words queued -> txd=1 immediately, fifo_level=0, and no further frames after release.
REQ-041 Scenario 6: push exactly on the final-stop tick of the previous frame while fifo_level=0 -> the frame goes IDLE, and the new word starts on the next tick.
